// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bundle: redirect/stall inputs from the pipeline, the
// instruction-memory request/acknowledge pair, and the IF/ID report.
//
// Handshake: if_req is the "valid" of the fetch address on pc. While
// if_req=1 and if_ack=0 the address is held stable. A rising edge that sees
// if_req=1 and if_ack=1 is the one transfer point. if_ack is ignored when
// if_req=0.
interface pc_fetch_ctrl_if #(
    parameter int ADDR_W = 32
);
    // Pipeline redirects and decode stall
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic              trap;
    logic [ADDR_W-1:0] trap_addr;
    logic              stall;

    // Instruction-memory handshake
    logic              if_ack;
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              if_req;

    // Report to IF/ID
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_pc;
    logic              misalign;

    // Controller side
    modport master (
        input  jump, jump_addr, trap, trap_addr, stall, if_ack,
        output pc, ce, if_req, fetch_valid, fetch_pc, misalign
    );

    // Pipeline / memory side
    modport slave (
        output jump, jump_addr, trap, trap_addr, stall, if_ack,
        input  pc, ce, if_req, fetch_valid, fetch_pc, misalign
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter and fetch-request controller. Owns the fetch address,
// issues if_req/if_ack fetches, applies trap > jump > pending > stall >
// sequential selection on ack edges, and parks redirects that arrive while
// a fetch is outstanding until the next ack.
module pc_fetch_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int RESET_VEC  = 0,
    parameter int STEP       = 4,
    parameter int ALIGN_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    pc_fetch_ctrl_if.master     fif,
    output logic                o_dbg_state
);

    typedef enum logic {
        ST_OFF   = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] STEP_W     = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              r_pend;
    logic              w_pend_nxt;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [ADDR_W-1:0] w_pend_addr_nxt;
    logic              r_pend_trap;
    logic              w_pend_trap_nxt;
    logic              r_fetch_valid;
    logic              w_fetch_valid_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic              r_misalign;
    logic              w_misalign_nxt;

    logic              w_redir;
    logic [ADDR_W-1:0] w_tgt;
    logic              w_ce;

    // State register: reset parks the controller in OFF
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, next pc, pending-redirect bookkeeping and IF/ID report
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pend_nxt        = r_pend;
        w_pend_addr_nxt   = r_pend_addr;
        w_pend_trap_nxt   = r_pend_trap;
        w_fetch_valid_nxt = 1'b0;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_misalign_nxt    = 1'b0;
        w_redir           = 1'b0;
        w_tgt             = '0;

        case (r_state)
            ST_OFF: begin
                // Redirects and acks are ignored until the first request
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (fif.if_ack) begin
                    if (fif.trap) begin
                        w_redir = 1'b1;
                        w_tgt   = fif.trap_addr;
                    end else if (fif.jump) begin
                        w_redir = 1'b1;
                        w_tgt   = fif.jump_addr;
                    end else if (r_pend) begin
                        w_redir = 1'b1;
                        w_tgt   = r_pend_addr;
                    end

                    // Any ack consumes the parked redirect
                    w_pend_nxt      = 1'b0;
                    w_pend_trap_nxt = 1'b0;

                    if (w_redir) begin
                        // Redirect kills the instruction just fetched
                        w_pc_nxt       = w_tgt & ~ALIGN_MASK;
                        w_misalign_nxt = |(w_tgt & ALIGN_MASK);
                    end else if (fif.stall) begin
                        // Re-request the same address; nothing delivered
                        w_pc_nxt = r_pc;
                    end else begin
                        w_pc_nxt          = r_pc + STEP_W;
                        w_fetch_valid_nxt = 1'b1;
                        w_fetch_pc_nxt    = r_pc;
                    end
                end else begin
                    // Fetch outstanding: pc holds, redirects are parked.
                    // A trap always wins the slot; a jump never displaces
                    // a parked trap but does replace a parked jump.
                    if (fif.trap) begin
                        w_pend_nxt      = 1'b1;
                        w_pend_addr_nxt = fif.trap_addr;
                        w_pend_trap_nxt = 1'b1;
                    end else if (fif.jump && !(r_pend && r_pend_trap)) begin
                        w_pend_nxt      = 1'b1;
                        w_pend_addr_nxt = fif.jump_addr;
                        w_pend_trap_nxt = 1'b0;
                    end
                end
            end
        endcase
    end

    // Datapath registers: pc, parked redirect and registered report
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_pend        <= 1'b0;
            r_pend_addr   <= '0;
            r_pend_trap   <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_pc    <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_pend        <= w_pend_nxt;
            r_pend_addr   <= w_pend_addr_nxt;
            r_pend_trap   <= w_pend_trap_nxt;
            r_fetch_valid <= w_fetch_valid_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_misalign    <= w_misalign_nxt;
        end
    end

    assign w_ce            = (r_state == ST_FETCH);
    assign fif.pc          = r_pc;
    assign fif.ce          = w_ce;
    assign fif.if_req      = w_ce;
    assign fif.fetch_valid = r_fetch_valid;
    assign fif.fetch_pc    = r_fetch_pc;
    assign fif.misalign    = r_misalign;
    assign o_dbg_state     = r_state;

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Parametrised program-counter and fetch-request controller; the next generation of the core's PC register. It owns the architectural fetch address, issues a request/acknowledge fetch to instruction memory, and applies trap and jump redirects with fixed priority, including redirects that arrive while a fetch is outstanding. It also applies decode-stage stalls and reports each accepted fetch to IF/ID as a one-cycle `fetch_valid` pulse.

## Interface
- `ADDR_W`, 32: width of every address bus.
- `RESET_VEC`, 0: value of `pc` in reset and the first fetch address.
- `STEP`, 4: byte increment per sequential fetch.
- `ALIGN_BITS`, 2: low address bits that must be zero in a redirect target.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-low (asserted at 0).
- `jump`  in  1  branch/jump redirect request from EX; single-cycle pulse.
- `jump_addr`  in  ADDR_W  jump target; sampled when `jump`=1.
- `trap`  in  1  exception redirect request; single-cycle pulse; priority over `jump`.
- `trap_addr`  in  ADDR_W  trap target; sampled when `trap`=1.
- `stall`  in  1  decode stall; sampled only in a cycle where `if_ack`=1.
- `if_ack`  in  1  memory has accepted the current fetch address.
- `pc`  out  ADDR_W  current fetch address; held stable while `if_req`=1 and `if_ack`=0.
- `ce`  out  1  chip enable to instruction memory.
- `if_req`  out  1  fetch request; equals `ce`.
- `fetch_valid`  out  1  registered; 1 for one cycle after an ack whose instruction is to be consumed.
- `fetch_pc`  out  ADDR_W  registered; address belonging to `fetch_valid`.
- `misalign`  out  1  registered one-cycle pulse: an applied redirect target had nonzero low bits.

## Operation
- States: OFF (`ce`=0) and FETCH (`ce`=1). Reset forces OFF. OFF always moves to FETCH on the next edge.
- While reset is asserted, outputs are: `pc`=RESET_VEC, `ce`=0, `if_req`=0, `fetch_valid`=0, `fetch_pc`=0, `misalign`=0.
- While reset is asserted, internal state is: pending flag=0, pending target=0, pending-is-trap=0.
- In OFF, `jump`, `trap` and `if_ack` are ignored.
- In FETCH, an edge with `if_ack`=1 selects the next `pc` by priority, highest first:
  - `trap`: `trap_addr`.
  - `jump`: `jump_addr`.
  - pending redirect: the pending target.
  - `stall`=1: `pc` holds, so the same address is re-requested.
  - otherwise: `pc`+STEP, modulo 2^ADDR_W.
- An ack edge also clears the pending flag.
- An ack edge sets `fetch_valid`<=1 and `fetch_pc`<=`pc` only if none of trap, jump, pending or stall applied. Otherwise `fetch_valid`<=0.
- In FETCH, an edge with `if_ack`=0 leaves `pc` unchanged. On that edge:
  - `trap` writes `trap_addr` into the pending register and sets pending-is-trap.
  - `jump` writes `jump_addr` only if no trap is already pending.
  - A later trap overwrites a pending jump.
  - A later jump overwrites a pending jump.
- Every redirect target (direct or pending) has its low ALIGN_BITS forced to 0 before loading `pc`. If any of those bits was 1, `misalign` pulses 1 on that same edge.
- `fetch_valid` and `misalign` are 0 on every edge not described above.

## Timing
- From reset release: the first rising edge sets `ce`=1 with `pc`=RESET_VEC. The earliest ack counts on the second edge.
- Fetch to `fetch_valid` latency: 1 cycle after the `if_ack` edge.
- Redirect with ack in the same cycle: new `pc` on that edge; the fetched instruction is killed.
- Redirect without ack: it is applied on the next ack edge. Exactly one wrong-path fetch completes and is killed.
- Trap and jump in the same cycle: trap wins; the jump is discarded.
- `stall` is ignored on non-ack edges.
- `pc` wrap: all ones + STEP wraps to STEP-1 (low bits), with no flag.
- Reset asserted mid-fetch: outputs take reset values immediately and asynchronously; pending state is lost.

## Test plan
- Reset release, `if_ack` held 1 -> `ce` rises at edge 1; `fetch_pc` sequence is 0x0, 0x4, 0x8 with `fetch_valid`=1 each cycle.
- `jump`=1 with `jump_addr`=0x100 and `if_ack`=1 at `pc`=0x8 -> next `pc`=0x100; no `fetch_valid` for 0x8; then 0x100 is valid.
- `jump` to 0x200 while `if_ack`=0 for 3 cycles, then ack -> `pc` holds 0x8 throughout; the 0x8 fetch is killed; next `pc`=0x200.
- Pending `jump` 0x200 followed by `trap` 0x80 before ack -> on ack `pc`=0x80. Also `trap`+`jump` in the same ack cycle -> `pc`=`trap_addr`.
- `stall`=1 on an ack at `pc`=0xC -> `pc` stays 0xC and `fetch_valid`=0; the next unstalled ack gives `fetch_pc`=0xC.
- Jump to 0x103 -> `pc`=0x100 and `misalign`=1 for one cycle. Reset pulsed during a pending redirect -> `pc`=RESET_VEC and the pending redirect is not applied afterward.
